// File: rtl/pio_debounce_bridge.sv
// ---------------------------------------------------------------------------
// pio_debounce_bridge
//
// Avalon-MM parallel-I/O peripheral for one board I/O group on the
// lightweight HPS-to-FPGA bridge. The raw inputs are synchronised and then
// debounced bit by bit. Edges of the debounced inputs are captured per bit,
// in a direction chosen per bit, and can raise a maskable level interrupt.
// The outputs come from one register that can be written whole or changed
// atomically through set/clear aliases.
//
// Register map (word address, unused high bits read 0):
//   0 DATA_IN  RO   debounced inputs
//   1 DATA_OUT RW   output register
//   2 IRQ_MASK RW   per-bit interrupt enable
//   3 EDGE_CAP W1C  captured edges
//   4 EDGE_SEL RW   0 = capture rising, 1 = capture falling
//   5 OUT_SET  WO   DATA_OUT |= wdata (reads 0)
//   6 OUT_CLR  WO   DATA_OUT &= ~wdata (reads 0)
//   7 reserved      reads 0, writes ignored
//
// Ports:
//   clk_clk         system clock
//   reset_reset_n   asynchronous active-low reset
//   avs_address     word address
//   avs_read        read strobe; avs_readdata is valid on the next cycle
//   avs_write       write strobe; takes effect on the same clock edge
//   avs_writedata   write data
//   avs_readdata    registered read data, held until the next read
//   pio_in_export   raw asynchronous inputs
//   pio_out_export  output register
//   irq             registered level interrupt
// ---------------------------------------------------------------------------
module pio_debounce_bridge #(
  parameter int unsigned          IN_WIDTH        = 10,
  parameter int unsigned          OUT_WIDTH       = 10,
  parameter int unsigned          SYNC_STAGES     = 2,
  parameter int unsigned          DEBOUNCE_CYCLES = 50000,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  input  logic [IN_WIDTH-1:0]  pio_in_export,
  output logic [OUT_WIDTH-1:0] pio_out_export,
  output logic                 irq
);

  localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
  localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd4;
  localparam logic [2:0] ADDR_OUT_SET  = 3'd5;
  localparam logic [2:0] ADDR_OUT_CLR  = 3'd6;

  logic [IN_WIDTH-1:0]  r_sync [SYNC_STAGES];
  logic [IN_WIDTH-1:0]  w_syncIn;
  logic [IN_WIDTH-1:0]  r_dataIn;
  logic [IN_WIDTH-1:0]  w_dNext;
  logic [IN_WIDTH-1:0]  r_mask;
  logic [IN_WIDTH-1:0]  r_edgeSel;
  logic [IN_WIDTH-1:0]  r_cap;
  logic [IN_WIDTH-1:0]  w_rise;
  logic [IN_WIDTH-1:0]  w_fall;
  logic [IN_WIDTH-1:0]  w_capSet;
  logic [IN_WIDTH-1:0]  w_capClr;
  logic [OUT_WIDTH-1:0] r_dataOut;
  logic [31:0]          w_rdData;
  logic [31:0]          r_rdData;
  logic                 r_irq;
  logic                 w_unusedWrData;

  // Write data wider than the registers is simply dropped.
  assign w_unusedWrData = ^avs_writedata;

  // Input synchroniser: a plain shift chain of SYNC_STAGES flops per bit.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= pio_in_export;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_syncIn = r_sync[SYNC_STAGES-1];

  // w_dNext is the value the debounced register takes at the next edge; the
  // edge detector uses it so captures land on the same edge as the toggle.
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign w_dNext = w_syncIn;
    end else begin : g_debounce
      localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] r_cnt [IN_WIDTH];

      // A bit follows the synchronised input only after it has disagreed for
      // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
      always_comb begin
        w_dNext = r_dataIn;
        for (int i = 0; i < int'(IN_WIDTH); i++) begin
          if ((w_syncIn[i] != r_dataIn[i]) && (r_cnt[i] == CNT_LAST)) begin
            w_dNext[i] = w_syncIn[i];
          end
        end
      end

      // Per-bit stability counters.
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
          for (int i = 0; i < int'(IN_WIDTH); i++) begin
            r_cnt[i] <= '0;
          end
        end else begin
          for (int i = 0; i < int'(IN_WIDTH); i++) begin
            if (w_syncIn[i] == r_dataIn[i]) begin
              r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
              r_cnt[i] <= '0;
            end else begin
              r_cnt[i] <= r_cnt[i] + 1'b1;
            end
          end
        end
      end
    end
  endgenerate

  // Debounced input register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_dataIn <= '0;
    end else begin
      r_dataIn <= w_dNext;
    end
  end

  // Edge detection in the direction chosen per bit. A coincident W1C loses
  // to a new edge so an event is never dropped.
  assign w_rise   = w_dNext & ~r_dataIn;
  assign w_fall   = ~w_dNext & r_dataIn;
  assign w_capSet = (w_rise & ~r_edgeSel) | (w_fall & r_edgeSel);
  assign w_capClr = (avs_write && (avs_address == ADDR_EDGE_CAP))
                    ? avs_writedata[IN_WIDTH-1:0] : '0;

  // Edge capture register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_cap <= '0;
    end else begin
      r_cap <= (r_cap & ~w_capClr) | w_capSet;
    end
  end

  // Software-writable control registers and the output register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_dataOut <= OUT_RESET;
      r_mask    <= '0;
      r_edgeSel <= '0;
    end else if (avs_write) begin
      case (avs_address)
        ADDR_DATA_OUT: r_dataOut <= avs_writedata[OUT_WIDTH-1:0];
        ADDR_IRQ_MASK: r_mask    <= avs_writedata[IN_WIDTH-1:0];
        ADDR_EDGE_SEL: r_edgeSel <= avs_writedata[IN_WIDTH-1:0];
        ADDR_OUT_SET:  r_dataOut <= r_dataOut | avs_writedata[OUT_WIDTH-1:0];
        ADDR_OUT_CLR:  r_dataOut <= r_dataOut & ~avs_writedata[OUT_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Read mux; registers narrower than 32 bits are zero-extended.
  always_comb begin
    w_rdData = '0;
    case (avs_address)
      ADDR_DATA_IN:  w_rdData[IN_WIDTH-1:0]  = r_dataIn;
      ADDR_DATA_OUT: w_rdData[OUT_WIDTH-1:0] = r_dataOut;
      ADDR_IRQ_MASK: w_rdData[IN_WIDTH-1:0]  = r_mask;
      ADDR_EDGE_CAP: w_rdData[IN_WIDTH-1:0]  = r_cap;
      ADDR_EDGE_SEL: w_rdData[IN_WIDTH-1:0]  = r_edgeSel;
      default:       w_rdData = '0;
    endcase
  end

  // Read data is sampled from the pre-write register state and held.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_rdData <= '0;
    end else if (avs_read) begin
      r_rdData <= w_rdData;
    end
  end

  // Interrupt is registered, so it trails CAP/MASK changes by one cycle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_cap & r_mask);
    end
  end

  assign avs_readdata   = r_rdData;
  assign pio_out_export = r_dataOut;
  assign irq            = r_irq;

endmodule
